// File: rtl/tmb_tx_link_ctrl.sv
// Bring-up and run-time sequencer for the TMB trigger fiber transmitter:
// PLL reset, GTX reset, phase sync and comma fill, with bounded retries and a sticky fault.
module tmb_tx_link_ctrl #(
  parameter int unsigned RST_CYC   = 8,
  parameter logic [15:0] LOCK_TMO  = 16'd50000,
  parameter int unsigned IDLE_CYC  = 256,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       TRG_CLK80,
  input  logic       RST_N,
  input  logic       START,
  input  logic       PRBS_REQ,
  input  logic       TX_PLL_LOCK,
  input  logic       TX_RESETDONE,
  input  logic       TX_SYNC_DONE,
  output logic       TX_PLLRST,
  output logic       GTXTXRST,
  output logic       TRG_RST,
  output logic       ENA_TEST_PAT,
  output logic       LINK_UP,
  output logic       FAULT,
  output logic [3:0] STATE,
  output logic [7:0] RETRY_CNT
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PLLRST    = 4'd1,
    S_WAIT_LOCK = 4'd2,
    S_GTXRST    = 4'd3,
    S_WAIT_DONE = 4'd4,
    S_WAIT_SYNC = 4'd5,
    S_COMMA     = 4'd6,
    S_RUN       = 4'd7,
    S_FAULT     = 4'd8
  } state_t;

  localparam logic [15:0] RST_LAST  = 16'(RST_CYC - 1);
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_CYC - 1);
  localparam logic [15:0] TMO_LAST  = LOCK_TMO - 16'd1;
  localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);

  state_t      state_r;
  state_t      state_nxt_s;
  state_t      norm_nxt_s;
  logic [15:0] timer_r;
  logic [7:0]  retry_r;
  logic        lock_meta_r, lock_sync_r;
  logic        done_meta_r, done_sync_r;
  logic        ena_r, pllrst_r, gtxrst_r, trgrst_r, link_r, fault_r;
  logic        timeout_s, wait_fail_s, lock_loss_s, fail_s;
  logic [2:0]  rst_pat_s;

  // Normal successor of each state; a wait state whose condition is still
  // low on its last allowed cycle flags a failure (the condition wins a tie).
  always_comb begin
    norm_nxt_s  = state_r;
    wait_fail_s = 1'b0;
    timeout_s   = (timer_r == TMO_LAST);
    case (state_r)
      S_IDLE: begin
        if (START) norm_nxt_s = S_PLLRST;
        else       norm_nxt_s = S_IDLE;
      end
      S_PLLRST: begin
        if (timer_r == RST_LAST) norm_nxt_s = S_WAIT_LOCK;
        else                     norm_nxt_s = S_PLLRST;
      end
      S_WAIT_LOCK: begin
        if (lock_sync_r)    norm_nxt_s = S_GTXRST;
        else if (timeout_s) wait_fail_s = 1'b1;
        else                norm_nxt_s = S_WAIT_LOCK;
      end
      S_GTXRST: begin
        if (timer_r == RST_LAST) norm_nxt_s = S_WAIT_DONE;
        else                     norm_nxt_s = S_GTXRST;
      end
      S_WAIT_DONE: begin
        if (done_sync_r)    norm_nxt_s = S_WAIT_SYNC;
        else if (timeout_s) wait_fail_s = 1'b1;
        else                norm_nxt_s = S_WAIT_DONE;
      end
      S_WAIT_SYNC: begin
        if (TX_SYNC_DONE)   norm_nxt_s = S_COMMA;
        else if (timeout_s) wait_fail_s = 1'b1;
        else                norm_nxt_s = S_WAIT_SYNC;
      end
      S_COMMA: begin
        if (timer_r == IDLE_LAST) norm_nxt_s = S_RUN;
        else                      norm_nxt_s = S_COMMA;
      end
      S_RUN: begin
        // A PRBS select change goes back through comma fill so the PRBS restarts aligned
        if (PRBS_REQ != ena_r) norm_nxt_s = S_COMMA;
        else                   norm_nxt_s = S_RUN;
      end
      S_FAULT:  norm_nxt_s = S_FAULT;
      default:  norm_nxt_s = S_IDLE;
    endcase
  end

  // Priority: START low, then failure (retry or fault), then normal progress
  always_comb begin
    lock_loss_s = ~lock_sync_r &&
                  (state_r inside {S_GTXRST, S_WAIT_DONE, S_WAIT_SYNC, S_COMMA, S_RUN});
    fail_s      = START && (wait_fail_s || lock_loss_s);
    if (!START) begin
      state_nxt_s = S_IDLE;
    end else if (fail_s) begin
      if (retry_r < RETRY_LIM) state_nxt_s = S_PLLRST;
      else                     state_nxt_s = S_FAULT;
    end else begin
      state_nxt_s = norm_nxt_s;
    end
  end

  // Reset-pin pattern {TX_PLLRST, GTXTXRST, TRG_RST} of the state being entered
  always_comb begin
    case (state_nxt_s)
      S_IDLE, S_PLLRST, S_FAULT:         rst_pat_s = 3'b111;
      S_WAIT_LOCK, S_GTXRST:             rst_pat_s = 3'b011;
      S_WAIT_DONE, S_WAIT_SYNC, S_COMMA: rst_pat_s = 3'b001;
      S_RUN:                             rst_pat_s = 3'b000;
      default:                           rst_pat_s = 3'b111;
    endcase
  end

  // State, timer, retry count, synchronisers and next-state-decoded outputs
  always_ff @(posedge TRG_CLK80) begin
    if (!RST_N) begin
      state_r     <= S_IDLE;
      timer_r     <= 16'd0;
      retry_r     <= 8'd0;
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
      done_meta_r <= 1'b0;
      done_sync_r <= 1'b0;
      ena_r       <= 1'b0;
      pllrst_r    <= 1'b1;
      gtxrst_r    <= 1'b1;
      trgrst_r    <= 1'b1;
      link_r      <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      lock_meta_r <= TX_PLL_LOCK;
      lock_sync_r <= lock_meta_r;
      done_meta_r <= TX_RESETDONE;
      done_sync_r <= done_meta_r;
      state_r     <= state_nxt_s;

      if (state_nxt_s != state_r)  timer_r <= 16'd0;
      else if (timer_r != 16'hFFFF) timer_r <= timer_r + 16'd1;
      else                         timer_r <= timer_r;

      if (state_nxt_s == S_IDLE)              retry_r <= 8'd0;
      else if (fail_s && retry_r != 8'hFF)    retry_r <= retry_r + 8'd1;
      else                                    retry_r <= retry_r;

      if (state_nxt_s == S_IDLE || state_nxt_s == S_FAULT)     ena_r <= 1'b0;
      else if (state_nxt_s == S_COMMA && state_r != S_COMMA)   ena_r <= PRBS_REQ;
      else                                                     ena_r <= ena_r;

      {pllrst_r, gtxrst_r, trgrst_r} <= rst_pat_s;
      link_r  <= (state_nxt_s == S_RUN);
      fault_r <= (state_nxt_s == S_FAULT);
    end
  end

  assign TX_PLLRST    = pllrst_r;
  assign GTXTXRST     = gtxrst_r;
  assign TRG_RST      = trgrst_r;
  assign ENA_TEST_PAT = ena_r;
  assign LINK_UP      = link_r;
  assign FAULT        = fault_r;
  assign STATE        = state_r;
  assign RETRY_CNT    = retry_r;

endmodule

// File: tb/tb_tmb_tx_link_ctrl.sv
// Scenario bench for tmb_tx_link_ctrl: randomized PHY delays and dwell times,
// expected state timing derived from the documented latencies.
module tb_tmb_tx_link_ctrl;

  localparam int RC  = 8;
  localparam int TMO = 100;
  localparam int IC  = 256;
  localparam int MR  = 3;

  localparam logic [3:0] S_IDLE = 4'd0, S_PLLRST = 4'd1, S_WLOCK = 4'd2, S_GTXRST = 4'd3,
                         S_WDONE = 4'd4, S_WSYNC = 4'd5, S_COMMA = 4'd6, S_RUN = 4'd7,
                         S_FAULT = 4'd8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, start = 1'b0, prbs = 1'b0;
  logic       lock = 1'b0, done = 1'b0, sync = 1'b0;
  logic       tx_pllrst, gtxtxrst, trg_rst, ena_test_pat, link_up, fault;
  logic [3:0] state;
  logic [7:0] retry;
  wire  [5:0] outs = {tx_pllrst, gtxtxrst, trg_rst, ena_test_pat, link_up, fault};

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic exp_ena = 1'b0;

  always #5 clk = ~clk;

  tmb_tx_link_ctrl #(
    .RST_CYC(RC), .LOCK_TMO(16'(TMO)), .IDLE_CYC(IC), .MAX_RETRY(MR)
  ) dut (
    .TRG_CLK80(clk), .RST_N(rst_n), .START(start), .PRBS_REQ(prbs),
    .TX_PLL_LOCK(lock), .TX_RESETDONE(done), .TX_SYNC_DONE(sync),
    .TX_PLLRST(tx_pllrst), .GTXTXRST(gtxtxrst), .TRG_RST(trg_rst),
    .ENA_TEST_PAT(ena_test_pat), .LINK_UP(link_up), .FAULT(fault),
    .STATE(state), .RETRY_CNT(retry)
  );

  // Expected {TX_PLLRST,GTXTXRST,TRG_RST,ENA_TEST_PAT,LINK_UP,FAULT} for a state
  function automatic logic [5:0] exp_outs(input logic [3:0] s, input logic ena);
    case (s)
      S_IDLE:                   return 6'b111_0_0_0;
      S_PLLRST:                 return {3'b111, ena, 2'b00};
      S_WLOCK, S_GTXRST:        return {3'b011, ena, 2'b00};
      S_WDONE, S_WSYNC, S_COMMA: return {3'b001, ena, 2'b00};
      S_RUN:                    return {3'b000, ena, 2'b10};
      S_FAULT:                  return 6'b111_0_0_1;
      default:                  return 6'b000_0_0_0;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Returns the cycle at which STATE reads s, or -1 if the budget runs out
  task automatic wait_state(input logic [3:0] s, input int budget, output int t);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      step();
      n++;
    end
    t = (state === s) ? cyc : -1;
  endtask

  task automatic shutdown();
    int t;
    start = 1'b0;
    wait_state(S_IDLE, 4, t);
    exp_ena = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) step();
    checks++;
    if (state !== S_IDLE || outs !== exp_outs(S_IDLE, 1'b0) || retry !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d outs=%b retry=%0d want state=0 outs=%b retry=0",
               state, outs, retry, exp_outs(S_IDLE, 1'b0));
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (state !== S_IDLE || outs !== exp_outs(S_IDLE, 1'b0)) begin
      errors++;
      $display("FAIL idle_hold: got state=%0d outs=%b want state=0", state, outs);
    end
  endtask

  task automatic test_bringup();
    int t0, t, tl, tg, td, ts, tc;
    logic p;
    p = 1'($urandom_range(0, 1));
    prbs = p; lock = 1'b0; done = 1'b0; sync = 1'b0;
    start = 1'b1;
    t0 = cyc;
    wait_state(S_WLOCK, RC + 5, t);
    checks++;
    if (t !== t0 + 1 + RC || outs !== exp_outs(S_WLOCK, 1'b0)) begin
      errors++;
      $display("FAIL pllrst_fall: got cycle=%0d outs=%b want cycle=%0d outs=%b",
               t - t0, outs, 1 + RC, exp_outs(S_WLOCK, 1'b0));
    end
    repeat ($urandom_range(5, 40)) step();
    lock = 1'b1;
    tl = cyc;
    wait_state(S_GTXRST, 10, tg);
    checks++;
    if (tg !== tl + 3) begin
      errors++;
      $display("FAIL lock_latency: got %0d want 3", tg - tl);
    end
    wait_state(S_WDONE, RC + 5, t);
    checks++;
    if (t !== tg + RC || outs !== exp_outs(S_WDONE, 1'b0)) begin
      errors++;
      $display("FAIL gtxrst_len: got %0d outs=%b want %0d", t - tg, outs, RC);
    end
    repeat ($urandom_range(5, 40)) step();
    done = 1'b1;
    td = cyc;
    wait_state(S_WSYNC, 10, t);
    checks++;
    if (t !== td + 3) begin
      errors++;
      $display("FAIL done_latency: got %0d want 3", t - td);
    end
    repeat ($urandom_range(2, 20)) step();
    sync = 1'b1;
    ts = cyc;
    wait_state(S_COMMA, 5, tc);
    exp_ena = p;
    checks++;
    if (tc !== ts + 1 || outs !== exp_outs(S_COMMA, exp_ena)) begin
      errors++;
      $display("FAIL comma_entry: got lat=%0d outs=%b want lat=1 outs=%b",
               tc - ts, outs, exp_outs(S_COMMA, exp_ena));
    end
    wait_state(S_RUN, IC + 5, t);
    checks++;
    if (t !== tc + IC || outs !== exp_outs(S_RUN, exp_ena) || retry !== 8'd0) begin
      errors++;
      $display("FAIL run_entry: got comma_len=%0d outs=%b retry=%0d want %0d outs=%b retry=0",
               t - tc, outs, retry, IC, exp_outs(S_RUN, exp_ena));
    end
  endtask

  task automatic test_lock_loss();
    int td, t;
    repeat ($urandom_range(1, 20)) step();
    lock = 1'b0;
    td = cyc;
    step();
    step();
    checks++;
    if (state !== S_RUN || link_up !== 1'b1) begin
      errors++;
      $display("FAIL lockloss_early: got state=%0d link=%b want state=7 link=1", state, link_up);
    end
    step();
    checks++;
    if (state !== S_PLLRST || outs !== exp_outs(S_PLLRST, exp_ena) || retry !== 8'd1) begin
      errors++;
      $display("FAIL lockloss_retry: got state=%0d outs=%b retry=%0d want state=1 outs=%b retry=1",
               state, outs, retry, exp_outs(S_PLLRST, exp_ena));
    end
    step();
    step();
    lock = 1'b1;
    wait_state(S_RUN, IC + 40, t);
    checks++;
    if (t !== td + 22 + IC || retry !== 8'd1 || outs !== exp_outs(S_RUN, exp_ena)) begin
      errors++;
      $display("FAIL lockloss_recover: got t=%0d retry=%0d outs=%b want t=%0d retry=1",
               t - td, retry, outs, 22 + IC);
    end
  endtask

  task automatic test_prbs_switch();
    int tp, t;
    for (int k = 0; k < 2; k++) begin
      repeat ($urandom_range(1, 10)) step();
      prbs = ~exp_ena;
      tp = cyc;
      step();
      exp_ena = prbs;
      checks++;
      if (state !== S_COMMA || outs !== exp_outs(S_COMMA, exp_ena)) begin
        errors++;
        $display("FAIL prbs_comma: got state=%0d outs=%b want state=6 outs=%b",
                 state, outs, exp_outs(S_COMMA, exp_ena));
      end
      repeat ($urandom_range(1, IC - 10)) step();
      checks++;
      if (state !== S_COMMA || trg_rst !== 1'b1 || ena_test_pat !== exp_ena) begin
        errors++;
        $display("FAIL prbs_mid: got state=%0d trg=%b ena=%b want 6 1 %b",
                 state, trg_rst, ena_test_pat, exp_ena);
      end
      wait_state(S_RUN, IC + 5, t);
      checks++;
      if (t !== tp + 1 + IC || outs !== exp_outs(S_RUN, exp_ena)) begin
        errors++;
        $display("FAIL prbs_run: got t=%0d outs=%b want t=%0d outs=%b",
                 t - tp, outs, 1 + IC, exp_outs(S_RUN, exp_ena));
      end
    end
  endtask

  task automatic test_fault();
    int t0, t;
    shutdown();
    lock = 1'b0; done = 1'b0; sync = 1'b0;
    repeat (4) step();
    start = 1'b1;
    t0 = cyc;
    for (int k = 0; k <= MR; k++) begin
      wait_state(S_WLOCK, RC + 5, t);
      if (k < MR) begin
        wait_state(S_PLLRST, TMO + 5, t);
        checks++;
        if (t !== t0 + 1 + (k + 1) * (RC + TMO) || retry !== 8'(k + 1)) begin
          errors++;
          $display("FAIL timeout_retry%0d: got t=%0d retry=%0d want t=%0d retry=%0d",
                   k, t - t0, retry, 1 + (k + 1) * (RC + TMO), k + 1);
        end
      end else begin
        wait_state(S_FAULT, TMO + 5, t);
        checks++;
        if (t !== t0 + 1 + (MR + 1) * (RC + TMO) || retry !== 8'(MR + 1) ||
            outs !== exp_outs(S_FAULT, 1'b0)) begin
          errors++;
          $display("FAIL fault_entry: got t=%0d retry=%0d outs=%b want t=%0d retry=%0d",
                   t - t0, retry, outs, 1 + (MR + 1) * (RC + TMO), MR + 1);
        end
      end
    end
    lock = 1'b1; done = 1'b1; sync = 1'b1;
    repeat ($urandom_range(5, 30)) step();
    checks++;
    if (state !== S_FAULT || fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_sticky: got state=%0d fault=%b want 8 1", state, fault);
    end
    start = 1'b0;
    step();
    checks++;
    if (state !== S_IDLE || retry !== 8'd0 || outs !== exp_outs(S_IDLE, 1'b0)) begin
      errors++;
      $display("FAIL fault_exit: got state=%0d retry=%0d outs=%b want 0 0", state, retry, outs);
    end
  endtask

  task automatic test_timeout_edge();
    int tw;
    for (int late = 0; late < 2; late++) begin
      shutdown();
      lock = 1'b1; done = 1'b0; sync = 1'b0;
      repeat (4) step();
      start = 1'b1;
      wait_state(S_WDONE, 3 * RC + 10, tw);
      while (cyc < tw + TMO - 3 + late) step();
      done = 1'b1;
      while (cyc < tw + TMO) step();
      checks++;
      if (late == 0 && (tw < 0 || state !== S_WSYNC || retry !== 8'd0)) begin
        errors++;
        $display("FAIL tmo_tie: got state=%0d retry=%0d want state=5 retry=0", state, retry);
      end else if (late == 1 && (tw < 0 || state !== S_PLLRST || retry !== 8'd1)) begin
        errors++;
        $display("FAIL tmo_late: got state=%0d retry=%0d want state=1 retry=1", state, retry);
      end
    end
  endtask

  task automatic test_abort();
    int t;
    shutdown();
    lock = 1'b1; done = 1'b0; sync = 1'b0;
    repeat (4) step();
    start = 1'b1;
    wait_state(S_WDONE, 3 * RC + 10, t);
    repeat ($urandom_range(1, 20)) step();
    rst_n = 1'b0;
    step();
    checks++;
    if (t < 0 || state !== S_IDLE || outs !== exp_outs(S_IDLE, 1'b0) || retry !== 8'd0) begin
      errors++;
      $display("FAIL abort_rst: got state=%0d outs=%b retry=%0d want state=0 outs=%b",
               state, outs, retry, exp_outs(S_IDLE, 1'b0));
    end
    rst_n = 1'b1;
    done = 1'b1; sync = 1'b1;
    wait_state(S_COMMA, 3 * RC + 20, t);
    repeat ($urandom_range(1, 200)) step();
    start = 1'b0;
    step();
    checks++;
    if (t < 0 || state !== S_IDLE || outs !== exp_outs(S_IDLE, 1'b0) || retry !== 8'd0) begin
      errors++;
      $display("FAIL abort_start: got state=%0d outs=%b retry=%0d want state=0 outs=%b",
               state, outs, retry, exp_outs(S_IDLE, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_loss();
    test_prbs_switch();
    test_fault();
    test_timeout_edge();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
